instr_fetch_unit: RTL and testbench

//  Upstream stage of the control unit. Fetches 16-bit instructions from the 8-bit byte memory as two

---
 rtl/cpu8_pkg.sv | 16 +
 rtl/fetch_queue.sv | 67 ++++++
 rtl/instr_fetch_unit.sv | 109 ++++++++++
 tb/tb_instr_fetch_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu8_pkg.sv
// Shared types and constants for the 8-bit-memory CPU: fetch FSM states, datapath widths and
// the opcode field values seen by decode.
package cpu8_pkg;

    typedef enum logic {S_LO, S_HI} fetch_state_t;

    localparam int unsigned INSTR_WIDTH = 16;
    localparam int unsigned BYTE_WIDTH  = 8;
    localparam int unsigned ADDR_WIDTH  = 16;

    localparam logic [3:0] INSTR_ALU   = 4'b0000;
    localparam logic [3:0] INSTR_MOVE  = 4'b0001;
    localparam logic [3:0] INSTR_MOVEI = 4'b0010;
    localparam logic [3:0] INSTR_JUMP  = 4'b0100;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO with a registered head word. The head register keeps its last value when
// the queue drains, so downstream sees stable data while valid is low.
module fetch_queue #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            push,
    input  logic                            pop,
    input  logic                            flush,
    input  logic [WIDTH-1:0]                wdata,
    output logic [WIDTH-1:0]                rdata,
    output logic [$clog2(DEPTH+1)-1:0]      count
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] store_q [DEPTH];
    logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH-1:0] head_q;
    logic             pop_ok;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign pop_ok = pop && (cnt_q != '0);
    assign rdata  = head_q;
    assign count  = cnt_q;

    always_ff @(posedge clk) begin
        if (!rst && !flush && push) begin
            store_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            head_q   <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop_ok) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            cnt_q <= cnt_q + CntW'(push) - CntW'(pop_ok);
            // Head follows the next stored entry, or the incoming word when nothing else is queued
            if (pop_ok && cnt_q > CntW'(1)) begin
                head_q <= store_q[ptr_inc(rd_ptr_q)];
            end else if (push && (cnt_q == '0 || (pop_ok && cnt_q == CntW'(1)))) begin
                head_q <= wdata;
            end
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetches 16-bit instructions as two byte reads (low at A, high at A+1), queues them for decode,
// yields the memory port on stall_mem and flushes everything on a redirect.
module instr_fetch_unit #(
    parameter int unsigned            ADDR_WIDTH  = 16,
    parameter int unsigned            QUEUE_DEPTH = 2,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_addr,
    input  logic                   stall_mem,
    output logic                   mem_req,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic [7:0]             mem_Q,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [15:0]            instr,
    output logic [ADDR_WIDTH-1:0]  instr_addr
);

    import cpu8_pkg::*;

    localparam int unsigned CntW = $clog2(QUEUE_DEPTH + 1);
    localparam int unsigned QW   = ADDR_WIDTH + INSTR_WIDTH;

    fetch_state_t            state_q;
    logic [ADDR_WIDTH-1:0]   fetch_pc_q, lo_addr_q;
    logic [BYTE_WIDTH-1:0]   lo_byte_q;
    logic                    pend_lo_q, pend_hi_q, inflight_q;
    logic                    issue_lo, issue_hi, can_issue;
    logic                    push, pop;
    logic [CntW-1:0]         q_count;
    logic [QW-1:0]           q_rdata;

    assign can_issue = !rst && !stall_mem && !redirect_valid;

    always_comb begin
        issue_lo = 1'b0;
        issue_hi = 1'b0;
        mem_addr = fetch_pc_q;
        if (state_q == S_LO) begin
            // Reserve a slot for the instruction being assembled so the queue never overflows
            issue_lo = can_issue && (32'(q_count) + 32'(inflight_q) < QUEUE_DEPTH);
        end else begin
            mem_addr = fetch_pc_q + ADDR_WIDTH'(1);
            issue_hi = can_issue;
        end
        mem_req = issue_lo || issue_hi;
    end

    assign push = pend_hi_q && !redirect_valid;
    assign pop  = instr_valid && instr_ready && !redirect_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_LO;
            fetch_pc_q <= RESET_PC;
            lo_addr_q  <= RESET_PC;
            lo_byte_q  <= '0;
            pend_lo_q  <= 1'b0;
            pend_hi_q  <= 1'b0;
            inflight_q <= 1'b0;
        end else if (redirect_valid) begin
            state_q    <= S_LO;
            fetch_pc_q <= redirect_addr;
            pend_lo_q  <= 1'b0;
            pend_hi_q  <= 1'b0;
            inflight_q <= 1'b0;
        end else begin
            pend_lo_q <= issue_lo;
            pend_hi_q <= issue_hi;
            if (pend_lo_q) begin
                lo_byte_q <= mem_Q;
            end
            if (pend_hi_q) begin
                inflight_q <= 1'b0;
            end
            if (issue_lo) begin
                inflight_q <= 1'b1;
                lo_addr_q  <= fetch_pc_q;
                state_q    <= S_HI;
            end
            if (issue_hi) begin
                fetch_pc_q <= fetch_pc_q + ADDR_WIDTH'(2);
                state_q    <= S_LO;
            end
        end
    end

    fetch_queue #(
        .WIDTH (QW),
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata ({lo_addr_q, mem_Q, lo_byte_q}),
        .rdata (q_rdata),
        .count (q_count)
    );

    assign instr_valid = (q_count != '0);
    assign instr       = q_rdata[INSTR_WIDTH-1:0];
    assign instr_addr  = q_rdata[QW-1:INSTR_WIDTH];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed and randomized bench for instr_fetch_unit; an instruction-stream scoreboard predicts
// every popped instruction from the byte memory and the current program counter.
module tb_instr_fetch_unit;

    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk, rst, redirect_valid, stall_mem, mem_req, instr_valid, instr_ready;
    logic [15:0] redirect_addr, mem_addr, instr, instr_addr;
    logic [7:0]  mem_Q;
    logic [7:0]  mem [65536];

    int          checks = 0;
    int          failures = 0;
    int          pops = 0;
    logic [15:0] exp_pc;

    instr_fetch_unit #(
        .ADDR_WIDTH  (16),
        .QUEUE_DEPTH (2),
        .RESET_PC    (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .stall_mem      (stall_mem),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_Q          (mem_Q),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_addr     (instr_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM; junk on the bus when not requested so stray captures show up
    always @(posedge clk) begin
        if (mem_req) mem_Q <= mem[mem_addr];
        else         mem_Q <= 8'($urandom);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] word_at(input logic [15:0] a);
        logic [15:0] b;
        b = a + 16'd1;
        return {mem[b], mem[a]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Mid-cycle sample: scoreboard for the instruction stream seen by decode
    task automatic sample();
        @(negedge clk);
        if (rst) begin
            exp_pc = RESET_PC;
        end else if (redirect_valid) begin
            exp_pc = redirect_addr;
        end else if (instr_valid && instr_ready) begin
            chk("pop_addr", 32'(instr_addr), 32'(exp_pc));
            chk("pop_instr", 32'(instr), 32'(word_at(exp_pc)));
            exp_pc = exp_pc + 16'd2;
            pops++;
        end
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        sample();
        while (!instr_valid && n < 20) begin
            tick();
            sample();
            n++;
        end
        chk(tag, 32'(instr_valid), 32'd1);
    endtask

    task automatic redirect_to(input logic [15:0] a);
        redirect_valid = 1'b1;
        redirect_addr  = a;
        sample();
        chk("no_req_on_redirect", 32'(mem_req), 32'd0);
        tick();
        redirect_valid = 1'b0;
    endtask

    initial begin
        int nreq, p0;
        logic [15:0] ra;
        rst = 1'b1; redirect_valid = 1'b0; redirect_addr = '0; stall_mem = 1'b0;
        instr_ready = 1'b0; exp_pc = RESET_PC;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h34; mem[1] = 8'h12; mem[2] = 8'h78; mem[3] = 8'h56;

        tick();
        sample();
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'(RESET_PC));
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", 32'(instr), 32'd0);
        chk("rst_instr_addr", 32'(instr_addr), 32'd0);
        tick();

        // Back-to-back fetch from address 0
        rst = 1'b0; instr_ready = 1'b1;
        sample(); chk("t1_req0", 32'(mem_req), 32'd1); chk("t1_addr0", 32'(mem_addr), 32'h0);
        chk("t1_valid_c0", 32'(instr_valid), 32'd0); tick();
        sample(); chk("t1_addr1", 32'(mem_addr), 32'h1); tick();
        sample(); chk("t1_addr2", 32'(mem_addr), 32'h2);
        chk("t1_valid_c2", 32'(instr_valid), 32'd0); tick();
        sample(); chk("t1_addr3", 32'(mem_addr), 32'h3); chk("t1_valid_c3", 32'(instr_valid), 32'd1);
        chk("t1_instr0", 32'(instr), 32'h1234); chk("t1_iaddr0", 32'(instr_addr), 32'h0); tick();
        sample(); chk("t1_valid_c4", 32'(instr_valid), 32'd0); chk("t1_addr4", 32'(mem_addr), 32'h4);
        tick();
        sample(); chk("t1_valid_c5", 32'(instr_valid), 32'd1); chk("t1_instr1", 32'(instr), 32'h5678);
        chk("t1_iaddr1", 32'(instr_addr), 32'h2); tick();

        // Decode not ready: exactly two instructions fetched, then the port goes quiet
        instr_ready = 1'b0;
        redirect_to(16'h0020);
        nreq = 0;
        for (int i = 0; i < 14; i++) begin
            sample();
            if (mem_req) nreq++;
            if (i >= 10) chk("t2_quiet", 32'(mem_req), 32'd0);
            tick();
        end
        chk("t2_nreq", 32'(nreq), 32'd4);
        sample(); chk("t2_head", 32'(instr_addr), 32'h20); tick();
        instr_ready = 1'b1;
        p0 = pops;
        for (int i = 0; i < 30 && pops - p0 < 4; i++) begin sample(); tick(); end
        chk("t2_drain", 32'(pops - p0 >= 4), 32'd1);

        // Stall between lo and hi
        redirect_to(16'h0010);
        sample(); chk("t3_lo_req", 32'(mem_req), 32'd1); chk("t3_lo_addr", 32'(mem_addr), 32'h10);
        tick();
        stall_mem = 1'b1;
        for (int i = 0; i < 3; i++) begin sample(); chk("t3_stalled", 32'(mem_req), 32'd0); tick(); end
        stall_mem = 1'b0;
        sample(); chk("t3_hi_req", 32'(mem_req), 32'd1); chk("t3_hi_addr", 32'(mem_addr), 32'h11);
        tick();
        wait_valid("t3_valid");
        chk("t3_instr", 32'(instr), 32'(word_at(16'h0010))); chk("t3_iaddr", 32'(instr_addr), 32'h10);
        tick();

        // Redirect with a hi capture pending and one queued entry
        instr_ready = 1'b0;
        redirect_to(16'h0030);
        for (int i = 0; i < 4; i++) begin sample(); tick(); end
        redirect_valid = 1'b1; redirect_addr = 16'h0040;
        sample(); chk("t4_valid_before", 32'(instr_valid), 32'd1); chk("t4_req", 32'(mem_req), 32'd0);
        tick();
        redirect_valid = 1'b0;
        sample(); chk("t4_flushed", 32'(instr_valid), 32'd0); chk("t4_addr", 32'(mem_addr), 32'h40);
        chk("t4_req_after", 32'(mem_req), 32'd1); tick();
        instr_ready = 1'b1;
        wait_valid("t4_valid");
        chk("t4_iaddr", 32'(instr_addr), 32'h40); chk("t4_instr", 32'(instr), 32'(word_at(16'h0040)));
        tick();

        // Wrap at the top of the address space
        redirect_to(16'hFFFF);
        sample(); chk("t5_lo", 32'(mem_addr), 32'hFFFF); tick();
        sample(); chk("t5_hi", 32'(mem_addr), 32'h0000); chk("t5_hi_req", 32'(mem_req), 32'd1); tick();
        sample(); chk("t5_next", 32'(mem_addr), 32'h0001); chk("t5_next_req", 32'(mem_req), 32'd1);
        tick();
        wait_valid("t5_valid");
        chk("t5_iaddr", 32'(instr_addr), 32'hFFFF);
        chk("t5_instr", 32'(instr), 32'({mem[0], mem[16'hFFFF]})); tick();

        // Reset mid-fetch overrides a simultaneous redirect and the pending capture
        redirect_to(16'h0050);
        sample(); tick();
        sample(); tick();
        rst = 1'b1; redirect_valid = 1'b1; redirect_addr = 16'h0070;
        sample(); tick();
        redirect_valid = 1'b0;
        sample();
        chk("t6_req", 32'(mem_req), 32'd0); chk("t6_addr", 32'(mem_addr), 32'(RESET_PC));
        chk("t6_valid", 32'(instr_valid), 32'd0); chk("t6_instr", 32'(instr), 32'd0);
        chk("t6_iaddr", 32'(instr_addr), 32'd0);
        tick();
        rst = 1'b0;
        sample(); chk("t6_first_req", 32'(mem_req), 32'd1);
        chk("t6_first_addr", 32'(mem_addr), 32'(RESET_PC)); tick();

        // Randomized traffic against the scoreboard
        for (int i = 0; i < 800; i++) begin
            rst            = ($urandom_range(0, 199) == 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 3))
                0:       ra = 16'hFFFE + 16'($urandom_range(0, 1));
                1:       ra = 16'($urandom) | 16'h0001;
                default: ra = 16'($urandom);
            endcase
            redirect_addr = ra;
            stall_mem     = ($urandom_range(0, 3) == 0);
            instr_ready   = ($urandom_range(0, 3) != 0);
            sample();
            chk("blocked_req", 32'(mem_req && (stall_mem || redirect_valid || rst)), 32'd0);
            tick();
        end

        rst = 1'b0; redirect_valid = 1'b0; stall_mem = 1'b0; instr_ready = 1'b1;
        p0 = pops;
        for (int i = 0; i < 40; i++) begin sample(); tick(); end
        chk("drain_rate", 32'(pops - p0 >= 10), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
